// File: rtl/mips_pkg.sv
// Shared MIPS decode types: ALU ops, control bundle, opcode/funct encodings
// and the operand bypass helper used by the decode stage.
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    alu_src_imm;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    illegal;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] dst;
        ctrl_t             ctrl;
    } slot_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // r0 reads as zero; a writeback landing this edge overrides the stale file read.
    function automatic logic [DATA_W-1:0] bypass(
        input logic [REG_AW-1:0] idx,
        input logic [DATA_W-1:0] rf_data,
        input logic              wb_v,
        input logic [REG_AW-1:0] wb_idx,
        input logic [DATA_W-1:0] wb_d
    );
        logic [DATA_W-1:0] res;
        res = rf_data;
        if (idx == '0) begin
            res = '0;
        end else if (wb_v && (wb_idx == idx)) begin
            res = wb_d;
        end
        return res;
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational MIPS decoder: control bundle, destination, source-use flags
// and extended immediate for one instruction word.
module decode_ctrl
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    output ctrl_t             ctrl_c,
    output logic [REG_AW-1:0] rs_c,
    output logic [REG_AW-1:0] rt_c,
    output logic [REG_AW-1:0] dst_c,
    output logic              use_rs_c,
    output logic              use_rt_c,
    output logic [DATA_W-1:0] imm_c
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] imm_z;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rs_c   = instr[25:21];
    assign rt_c   = instr[20:16];
    assign rd     = instr[15:11];
    assign imm_s  = {{16{instr[15]}}, instr[15:0]};
    assign imm_z  = {16'h0000, instr[15:0]};

    always_comb begin
        ctrl_c   = '0;
        dst_c    = '0;
        use_rs_c = 1'b0;
        use_rt_c = 1'b0;
        imm_c    = '0;
        unique case (opcode)
            OP_RTYPE: begin
                use_rs_c         = 1'b1;
                use_rt_c         = 1'b1;
                dst_c            = rd;
                ctrl_c.reg_write = 1'b1;
                unique case (funct)
                    FN_ADD:  ctrl_c.alu_op = ALU_ADD;
                    FN_SUB:  ctrl_c.alu_op = ALU_SUB;
                    FN_AND:  ctrl_c.alu_op = ALU_AND;
                    FN_OR:   ctrl_c.alu_op = ALU_OR;
                    FN_SLT:  ctrl_c.alu_op = ALU_SLT;
                    default: ctrl_c.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
                use_rs_c           = 1'b1;
                dst_c              = rt_c;
                ctrl_c.alu_src_imm = 1'b1;
                ctrl_c.reg_write   = 1'b1;
                ctrl_c.mem_read    = (opcode == OP_LW);
                imm_c              = imm_s;
                if (opcode == OP_ANDI) begin
                    ctrl_c.alu_op = ALU_AND;
                    imm_c         = imm_z;
                end else if (opcode == OP_ORI) begin
                    ctrl_c.alu_op = ALU_OR;
                    imm_c         = imm_z;
                end
            end
            OP_SW: begin
                use_rs_c           = 1'b1;
                use_rt_c           = 1'b1;
                ctrl_c.alu_src_imm = 1'b1;
                ctrl_c.mem_write   = 1'b1;
                imm_c              = imm_s;
            end
            OP_BEQ: begin
                use_rs_c      = 1'b1;
                use_rt_c      = 1'b1;
                ctrl_c.alu_op = ALU_SUB;
                ctrl_c.branch = 1'b1;
                imm_c         = imm_s;
            end
            default: ctrl_c.illegal = 1'b1;
        endcase
        // Illegal words must not touch architectural state or stall on sources.
        if (ctrl_c.illegal) begin
            ctrl_c   = '0;
            ctrl_c.illegal = 1'b1;
            dst_c    = '0;
            use_rs_c = 1'b0;
            use_rt_c = 1'b0;
            imm_c    = '0;
        end
        if (dst_c == '0) begin
            ctrl_c.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: register-file read, busy scoreboard hazard stall,
// writeback bypass, and a one-entry output slot towards execute.
module decode_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] in_pc,
    output logic [REG_AW-1:0] read_1,
    output logic [REG_AW-1:0] read_2,
    input  logic [DATA_W-1:0] data_reg_1,
    input  logic [DATA_W-1:0] data_reg_2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_dst,
    output ctrl_t             out_ctrl,
    output logic [DATA_W-1:0] out_pc
);

    ctrl_t             dec_ctrl;
    logic [REG_AW-1:0] rs_idx;
    logic [REG_AW-1:0] rt_idx;
    logic [REG_AW-1:0] dec_dst;
    logic              use_rs;
    logic              use_rt;
    logic [DATA_W-1:0] dec_imm;

    slot_state_t       state_q, state_d;
    slot_t             slot_q, slot_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [NREGS-1:0]  wb_clr, flush_clr, issue_set, busy_live;
    logic              stall, accept;

    decode_ctrl u_decode_ctrl (
        .instr    (instr),
        .ctrl_c   (dec_ctrl),
        .rs_c     (rs_idx),
        .rt_c     (rt_idx),
        .dst_c    (dec_dst),
        .use_rs_c (use_rs),
        .use_rt_c (use_rt),
        .imm_c    (dec_imm)
    );

    assign read_1 = rs_idx;
    assign read_2 = rt_idx;

    // Hazard check sees the scoreboard after this cycle's writeback retires.
    always_comb begin
        wb_clr = '0;
        if (wb_valid && (wb_dst != '0)) begin
            wb_clr[wb_dst] = 1'b1;
        end
        busy_live = busy_q & ~wb_clr;
        stall = (use_rs && busy_live[rs_idx])
              || (use_rt && busy_live[rt_idx])
              || busy_live[dec_dst];
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL: begin
                if (accept) begin
                    state_d = SLOT_FULL;
                end else if (out_ready || flush) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    // Slot outputs and handshake.
    always_comb begin
        out_valid = (state_q == SLOT_FULL);
        in_ready  = rst_n && !stall && (!out_valid || out_ready || flush);
        accept    = in_valid && in_ready;
    end

    // Slot payload load and scoreboard update; issue set beats any clear.
    always_comb begin
        slot_d    = slot_q;
        flush_clr = '0;
        issue_set = '0;
        if (accept) begin
            slot_d.pc      = in_pc;
            slot_d.rs_data = bypass(rs_idx, data_reg_1, wb_valid, wb_dst, wb_data);
            slot_d.rt_data = bypass(rt_idx, data_reg_2, wb_valid, wb_dst, wb_data);
            slot_d.imm     = dec_imm;
            slot_d.dst     = dec_dst;
            slot_d.ctrl    = dec_ctrl;
            if (dec_ctrl.reg_write) begin
                issue_set[dec_dst] = 1'b1;
            end
        end
        if (flush && out_valid && slot_q.ctrl.reg_write) begin
            flush_clr[slot_q.dst] = 1'b1;
        end
        busy_d = ((busy_q & ~wb_clr & ~flush_clr) | issue_set) & ~NREGS'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            busy_q <= '0;
        end else begin
            slot_q <= slot_d;
            busy_q <= busy_d;
        end
    end

    assign out_rs_data = slot_q.rs_data;
    assign out_rt_data = slot_q.rt_data;
    assign out_imm     = slot_q.imm;
    assign out_dst     = slot_q.dst;
    assign out_ctrl    = slot_q.ctrl;
    assign out_pc      = slot_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push expected slot
// contents; a negedge monitor pops and compares on every out_valid & out_ready.
module tb_decode_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] instr, in_pc;
    logic [4:0]  read_1, read_2;
    logic [31:0] data_reg_1, data_reg_2;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_rs_data, out_rt_data, out_imm, out_pc;
    logic [4:0]  out_dst;
    ctrl_t       out_ctrl;

    int n_vec = 0;
    int n_err = 0;
    slot_t exp_q[$];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .in_pc(in_pc),
        .read_1(read_1), .read_2(read_2),
        .data_reg_1(data_reg_1), .data_reg_2(data_reg_2),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
        .out_imm(out_imm), .out_dst(out_dst),
        .out_ctrl(out_ctrl), .out_pc(out_pc)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic ctrl_t mk_ctrl(input alu_op_t op, input logic src_imm, input logic rw,
                                      input logic mr, input logic mw, input logic br,
                                      input logic ill);
        ctrl_t c;
        c.alu_op      = op;
        c.alu_src_imm = src_imm;
        c.reg_write   = rw;
        c.mem_read    = mr;
        c.mem_write   = mw;
        c.branch      = br;
        c.illegal     = ill;
        return c;
    endfunction

    function automatic slot_t mk_slot(input logic [31:0] pc, input logic [31:0] rs,
                                      input logic [31:0] rt, input logic [31:0] imm,
                                      input logic [4:0] dst, input ctrl_t c);
        slot_t s;
        s.pc = pc; s.rs_data = rs; s.rt_data = rt; s.imm = imm; s.dst = dst; s.ctrl = c;
        return s;
    endfunction

    // Monitor: every consumed slot must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: pc 0x%08h consumed with no expectation", out_pc);
            end else begin
                slot_t e;
                e = exp_q.pop_front();
                check32("out_pc", out_pc, e.pc);
                check32("out_rs_data", out_rs_data, e.rs_data);
                check32("out_rt_data", out_rt_data, e.rt_data);
                check32("out_imm", out_imm, e.imm);
                check32("out_dst", 32'(out_dst), 32'(e.dst));
                check32("out_ctrl", 32'(out_ctrl), 32'(e.ctrl));
            end
        end
    end

    task automatic present(input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] d1, input logic [31:0] d2);
        instr = ins; in_pc = pc; data_reg_1 = d1; data_reg_2 = d2; in_valid = 1'b1;
    endtask

    // Holds in_valid until accepted (bounded); returns cycles waited before accept.
    task automatic wait_accept(input slot_t e, output int waited);
        bit done = 1'b0;
        waited = 0;
        while (!done && waited < 20) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) waited++;
        end
        in_valid = 1'b0;
        wb_valid = 1'b0;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL accept_timeout: pc 0x%08h not accepted, got in_ready=0 expected 1", e.pc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; in_pc = '0;
        data_reg_1 = '0; data_reg_2 = '0; wb_valid = 1'b0; wb_dst = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check32("rst_out_valid", 32'(out_valid), 32'd0);
        check32("rst_in_ready", 32'(in_ready), 32'd0);
        check32("rst_busy", dut.busy_q, 32'd0);
        check32("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        check32("rst_out_pc", out_pc, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // addi r7,r0,5
        present(32'h2007_0005, 32'h100, 32'h1234, 32'h77);
        wait_accept(mk_slot(32'h100, 32'h0, 32'h77, 32'h5, 5'd7,
                            mk_ctrl(ALU_ADD, 1, 1, 0, 0, 0, 0)), w);
        check32("addi_out_valid", 32'(out_valid), 32'd1);
        check32("addi_busy", dut.busy_q, 32'h0000_0080);

        // add r3,r7,r7 stalls on r7 until its writeback, which is forwarded
        present(32'h00E7_1820, 32'h104, 32'h0, 32'h0);
        @(negedge clk);
        check32("raw_stall_1", 32'(in_ready), 32'd0);
        @(negedge clk);
        check32("raw_stall_2", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_dst = 5'd7; wb_data = 32'd5;
        wait_accept(mk_slot(32'h104, 32'd5, 32'd5, 32'h0, 5'd3,
                            mk_ctrl(ALU_ADD, 0, 1, 0, 0, 0, 0)), w);
        check32("add_wait", 32'(w), 32'd0);
        check32("add_busy", dut.busy_q, 32'h0000_0008);

        // ori r5,r0,0xFF00 then back-pressure for 3 cycles
        present(32'h3405_FF00, 32'h108, 32'h0, 32'h0);
        wait_accept(mk_slot(32'h108, 32'h0, 32'h0, 32'h0000_FF00, 5'd5,
                            mk_ctrl(ALU_OR, 1, 1, 0, 0, 0, 0)), w);
        out_ready = 1'b0;
        present(32'h3006_8001, 32'h10C, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("bp_in_ready", 32'(in_ready), 32'd0);
            check32("bp_out_valid", 32'(out_valid), 32'd1);
            check32("bp_out_pc", out_pc, 32'h108);
            check32("bp_out_imm", out_imm, 32'h0000_FF00);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept(mk_slot(32'h10C, 32'h0, 32'h0, 32'h0000_8001, 5'd6,
                            mk_ctrl(ALU_AND, 1, 1, 0, 0, 0, 0)), w);
        check32("andi_wait", 32'(w), 32'd0);
        check32("andi_busy", dut.busy_q, 32'h0000_0068);

        // addi r0,r0,9 writes nothing; add r1,r0,r0 ignores file data for r0
        present(32'h2000_0009, 32'h110, 32'h0, 32'h0);
        wait_accept(mk_slot(32'h110, 32'h0, 32'h0, 32'h9, 5'd0,
                            mk_ctrl(ALU_ADD, 1, 0, 0, 0, 0, 0)), w);
        check32("addi_r0_busy", dut.busy_q, 32'h0000_0068);
        present(32'h0000_0820, 32'h114, 32'hDEAD, 32'hBEEF);
        wait_accept(mk_slot(32'h114, 32'h0, 32'h0, 32'h0, 5'd1,
                            mk_ctrl(ALU_ADD, 0, 1, 0, 0, 0, 0)), w);
        check32("add_r1_busy", dut.busy_q, 32'h0000_006A);

        // lw r4 held then flushed; sw reading r4 must issue without stall
        present(32'h8C04_0000, 32'h118, 32'h0, 32'h0);
        wait_accept(mk_slot(32'h118, 32'h0, 32'h0, 32'h0, 5'd4,
                            mk_ctrl(ALU_ADD, 1, 1, 1, 0, 0, 0)), w);
        out_ready = 1'b0;
        check32("lw_busy", dut.busy_q, 32'h0000_007A);
        flush = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b1;
        check32("flush_out_valid", 32'(out_valid), 32'd0);
        check32("flush_busy", dut.busy_q, 32'h0000_006A);
        present(32'hAC04_0008, 32'h11C, 32'h0, 32'h44);
        wait_accept(mk_slot(32'h11C, 32'h0, 32'h44, 32'h8, 5'd0,
                            mk_ctrl(ALU_ADD, 1, 0, 0, 1, 0, 0)), w);
        check32("sw_wait", 32'(w), 32'd0);

        // beq r0,r0,-4 sign-extends the offset
        present(32'h1000_FFFC, 32'h120, 32'h0, 32'h0);
        wait_accept(mk_slot(32'h120, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd0,
                            mk_ctrl(ALU_SUB, 0, 0, 0, 0, 1, 0)), w);

        // opcode 0x3F is illegal and writes nothing
        present(32'hFC00_0000, 32'h124, 32'h0, 32'h0);
        wait_accept(mk_slot(32'h124, 32'h0, 32'h0, 32'h0, 5'd0,
                            mk_ctrl(ALU_ADD, 0, 0, 0, 0, 0, 1)), w);
        check32("illegal_busy", dut.busy_q, 32'h0000_006A);

        // addi r9 held, then reset mid-operation
        present(32'h2009_0001, 32'h128, 32'h0, 32'h0);
        wait_accept(mk_slot(32'h128, 32'h0, 32'h0, 32'h1, 5'd9,
                            mk_ctrl(ALU_ADD, 1, 1, 0, 0, 0, 0)), w);
        out_ready = 1'b0;
        check32("pre_rst_busy", dut.busy_q, 32'h0000_026A);
        void'(exp_q.pop_back());
        rst_n = 1'b0;
        #1;
        check32("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check32("mid_rst_busy", dut.busy_q, 32'd0);
        check32("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check32("mid_rst_out_dst", 32'(out_dst), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check32("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
